// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sub_pkg
// Brief    : Shared types and helpers for the bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the bit counter: enough to index every operand bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_sub_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_if
// Brief    : Request/result bundle between a requester and serial_sub.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_sub_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a_in, b_in, bin,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a_in, b_in, bin,
    output busy, done, diff, borrow_out
  );

endinterface
`default_nettype wire

// File: rtl/serial_sub_fullsub.sv
`default_nettype none
// ============================================================================
// Module   : fullsub
// Brief    : One-bit full subtractor cell, di = a - b - c, bo = borrow.
// Revision : 1.0 - initial release
// ============================================================================
module fullsub (
  input  wire logic a,
  input  wire logic b,
  input  wire logic c,
  output logic      di,
  output logic      bo
);

  assign di = a ^ b ^ c;
  assign bo = (~a & b) | (~a & c) | (b & c);

endmodule
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub
// Brief    : Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first,
//            one bit per clock through a single fullsub cell.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  serial_sub_if.slave  bus
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  // Holds the WIDTH-1 difference bits already produced; the current cell
  // output completes the word, so the shifted-out LSB never needs storing.
  logic [WIDTH-2:0]   diff_sh_q, diff_sh_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               brw_q, brw_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               cell_di;
  logic               cell_bo;
  logic [WIDTH-1:0]   diff_word;

  fullsub u_cell (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .c  (brw_q),
    .di (cell_di),
    .bo (cell_bo)
  );

  assign diff_word = {cell_di, diff_sh_q};

  // Next-state logic: accept in IDLE, shift one bit per cycle in RUN.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    diff_d    = diff_q;
    brw_d     = brw_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a_in;
          b_sh_d  = bus.b_in;
          brw_d   = bus.bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_sh_d = diff_word[WIDTH-1:1];
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        brw_d     = cell_bo;
        if (cnt_q == LAST_BIT) begin
          diff_d   = diff_word;
          borrow_d = cell_bo;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      diff_q    <= '0;
      brw_q     <= 1'b0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      diff_q    <= diff_d;
      brw_q     <= brw_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub
// Brief    : Self-checking bench for serial_sub at WIDTH=8 and WIDTH=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8)) bus8 ();
  serial_sub_if #(.WIDTH(4)) bus4 ();

  serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  // {borrow, diff} of a - b - bin in (w+1)-bit two's complement.
  function automatic int ref_sub(input int a, input int b, input int bi, input int w);
    int r;
    r = a - b - bi;
    return (r + (2 << w)) & ((2 << w) - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t = cycles since acceptance (-1 when idle). Busy for WIDTH
  // cycles, done on the next, results appear with done and then hold.
  int       t8 = -1, t4 = -1;
  int       pend8, pend4;
  int       m8_res = 0, m4_res = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      t8 = -1; m8_res = 0; checking = 1'b1;
    end else if (t8 < 0) begin
      if (bus8.start) begin
        t8 = 0;
        pend8 = ref_sub(int'(bus8.a_in), int'(bus8.b_in), int'(bus8.bin), 8);
      end
    end else begin
      t8++;
      if (t8 == 8) m8_res = pend8;
      else if (t8 == 9) t8 = -1;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      t4 = -1; m4_res = 0;
    end else if (t4 < 0) begin
      if (bus4.start) begin
        t4 = 0;
        pend4 = ref_sub(int'(bus4.a_in), int'(bus4.b_in), int'(bus4.bin), 4);
      end
    end else begin
      t4++;
      if (t4 == 4) m4_res = pend4;
      else if (t4 == 5) t4 = -1;
    end
  end

  // Cycle-by-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("busy8", int'(bus8.busy), int'(t8 >= 0 && t8 < 8));
      chk("done8", int'(bus8.done), int'(t8 == 8));
      chk("res8", int'({bus8.borrow_out, bus8.diff}), m8_res);
      chk("busy4", int'(bus4.busy), int'(t4 >= 0 && t4 < 4));
      chk("done4", int'(bus4.done), int'(t4 == 4));
      chk("res4", int'({bus4.borrow_out, bus4.diff}), m4_res);
    end
  end

  task automatic wait_done8(input int limit);
    int n = 0;
    while (!bus8.done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done8_timeout", int'(bus8.done), 1);
  endtask

  task automatic wait_done4(input int limit);
    int n = 0;
    while (!bus4.done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done4_timeout", int'(bus4.done), 1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] ed, input logic eb);
    @(negedge clk);
    bus8.a_in = a; bus8.b_in = b; bus8.bin = bi; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.bin = 1'($urandom);
    wait_done8(30);
    chk("lit_diff8", int'(bus8.diff), int'(ed));
    chk("lit_bo8", int'(bus8.borrow_out), int'(eb));
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    int exp;
    exp = (int'(a) - int'(b) - int'(bi) + 32) % 32;
    @(negedge clk);
    bus4.a_in = a; bus4.b_in = b; bus4.bin = bi; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    wait_done4(20);
    chk("exh4", int'({bus4.borrow_out, bus4.diff}), exp);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.bin = 1'b0;
    bus4.start = 1'b0; bus4.a_in = '0; bus4.b_in = '0; bus4.bin = 1'b0;

    // Pin the reference arithmetic with hand-computed values.
    chk("pin_5a_3c", ref_sub(32'h5A, 32'h3C, 0, 8), 32'h01E);
    chk("pin_00_01", ref_sub(32'h00, 32'h01, 0, 8), 32'h1FF);
    chk("pin_ff_ff", ref_sub(32'hFF, 32'hFF, 1, 8), 32'h1FF);
    chk("pin_w4", ref_sub(3, 5, 1, 4), 32'h1D);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", int'(bus8.busy), 0);
    chk("rst_done", int'(bus8.done), 0);
    chk("rst_diff", int'(bus8.diff), 0);
    chk("rst_bo", int'(bus8.borrow_out), 0);
    repeat (20) @(negedge clk);

    op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    op8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Start held high through an operation: exactly one completion.
    @(negedge clk);
    bus8.a_in = 8'h80; bus8.b_in = 8'h01; bus8.bin = 1'b0; bus8.start = 1'b1;
    dones = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus8.done) dones++;
      if (i == 9) chk("held_diff", int'(bus8.diff), 32'h7F);
    end
    chk("held_one_done", dones, 1);
    chk("held_idle", int'(bus8.busy), 0);
    bus8.start = 1'b0;
    op8(8'h12, 8'h34, 1'b0, 8'hDE, 1'b1);

    // Reset in the fourth RUN cycle abandons the operation.
    @(negedge clk);
    bus8.a_in = 8'hAA; bus8.b_in = 8'h55; bus8.bin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", int'(bus8.busy), 0);
    chk("midrst_diff", int'(bus8.diff), 0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus8.done) dones++;
    end
    chk("midrst_no_done", dones, 0);
    op8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0);

    // Random requests at random times, including while busy.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus8.start = ($urandom_range(0, 3) == 0);
      bus8.a_in  = 8'($urandom);
      bus8.b_in  = 8'($urandom);
      bus8.bin   = 1'($urandom);
    end
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (12) @(negedge clk);

    // Exhaustive WIDTH=4 sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bi = 0; bi < 2; bi++)
          op4(4'(a), 4'(b), 1'(bi));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
